tof_echo_timer: RTL and testbench

// Receive-side partner of the ToF delay line. Timestamps each emitted start pulse, pairs it
// in FIFO order with the next returned echo pulse, and reports the round-trip delay in cycles.

---
 rtl/tof_echo_timer.sv | 136 +++++++++++++
 tb/tb_tof_echo_timer.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/tof_echo_timer.sv
// Echo-side timer: stamps each start pulse, pairs it in FIFO order with the next echo, and
// streams the round-trip delay (or a timeout record) out through a 2-deep result FIFO.
module tof_echo_timer #(
    parameter int MAX_DELAY = 256,
    parameter int SLOTS     = 8
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         clk_en,
    input  logic                         start_pulse,
    input  logic                         echo_pulse,
    output logic                         meas_valid,
    input  logic                         meas_ready,
    output logic [$clog2(MAX_DELAY)-1:0] meas_delay,
    output logic                         meas_timeout,
    output logic [$clog2(SLOTS+1)-1:0]   pending_o,
    output logic                         start_drop,
    output logic                         stray_echo,
    output logic                         meas_drop
);

    localparam int WDL = $clog2(MAX_DELAY);
    localparam int AW  = WDL + 1;
    localparam int PW  = $clog2(SLOTS);
    localparam int CW  = $clog2(SLOTS + 1);

    logic [PW-1:0]  rd_q, rd_d, wr_q, wr_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [AW-1:0]  age_q [SLOTS];
    logic [AW-1:0]  age_d [SLOTS];
    logic [AW-1:0]  head_age;
    logic [PW-1:0]  idx;
    logic           echo_hit, tmo, retire, accept;
    logic [WDL:0]   res_new;
    logic [WDL:0]   res_q [2];
    logic           rptr_q, rptr_d, wptr_q, wptr_d;
    logic [1:0]     rcnt_q, rcnt_d;
    logic           pop, push_ok;
    logic           sd_q, sd_d, se_q, se_d, md_q, md_d;

    function automatic logic [WDL-1:0] age_to_delay(input logic [AW-1:0] age);
        logic [AW-1:0] d;
        d = age - AW'(1);
        return d[WDL-1:0];
    endfunction

    always_comb begin
        rd_d    = rd_q;
        wr_d    = wr_q;
        cnt_d   = cnt_q;
        age_d   = age_q;
        idx     = '0;
        rptr_d  = rptr_q;
        wptr_d  = wptr_q;
        rcnt_d  = rcnt_q;

        // Age seen this cycle already includes this cycle's increment.
        head_age = age_q[rd_q] + AW'(1);
        echo_hit = echo_pulse && (cnt_q != '0);
        tmo      = !echo_pulse && (cnt_q != '0) && (head_age == AW'(MAX_DELAY));
        retire   = echo_hit || tmo;
        accept   = start_pulse && ((cnt_q != CW'(SLOTS)) || retire);

        res_new  = tmo ? {1'b1, {WDL{1'b1}}} : {1'b0, age_to_delay(head_age)};

        pop      = meas_valid && meas_ready;
        push_ok  = retire && ((rcnt_q != 2'd2) || pop);

        sd_d     = start_pulse && !accept;
        se_d     = echo_pulse && (cnt_q == '0);
        md_d     = retire && !push_ok;

        for (int i = 0; i < SLOTS; i++) begin
            idx = PW'(i) - rd_q;
            if (CW'(idx) < cnt_q) begin
                age_d[i] = age_q[i] + AW'(1);
            end
        end
        // When full and retiring, the new start reuses the slot just vacated.
        if (accept) begin
            age_d[wr_q] = '0;
        end

        rd_d   = rd_q + PW'(retire);
        wr_d   = wr_q + PW'(accept);
        cnt_d  = cnt_q + CW'(accept) - CW'(retire);
        rptr_d = rptr_q ^ pop;
        wptr_d = wptr_q ^ push_ok;
        rcnt_d = rcnt_q + 2'(push_ok) - 2'(pop);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_q   <= '0;
            wr_q   <= '0;
            cnt_q  <= '0;
            for (int i = 0; i < SLOTS; i++) begin
                age_q[i] <= '0;
            end
            rptr_q <= 1'b0;
            wptr_q <= 1'b0;
            rcnt_q <= '0;
            sd_q   <= 1'b0;
            se_q   <= 1'b0;
            md_q   <= 1'b0;
        end else begin
            if (clk_en) begin
                rd_q   <= rd_d;
                wr_q   <= wr_d;
                cnt_q  <= cnt_d;
                age_q  <= age_d;
                rptr_q <= rptr_d;
                wptr_q <= wptr_d;
                rcnt_q <= rcnt_d;
            end
            sd_q <= clk_en && sd_d;
            se_q <= clk_en && se_d;
            md_q <= clk_en && md_d;
        end
    end

    always_ff @(posedge clk) begin
        if (clk_en && push_ok) begin
            res_q[wptr_q] <= res_new;
        end
    end

    assign meas_valid   = (rcnt_q != '0);
    assign meas_delay   = meas_valid ? res_q[rptr_q][WDL-1:0] : '0;
    assign meas_timeout = meas_valid ? res_q[rptr_q][WDL] : 1'b0;
    assign pending_o    = cnt_q;
    assign start_drop   = sd_q;
    assign stray_echo   = se_q;
    assign meas_drop    = md_q;

endmodule

// File: tb/tb_tof_echo_timer.sv
// Bench for tof_echo_timer: directed scenarios plus random traffic, compared every cycle
// against a timestamp-queue model of pairing, timeouts and the 2-deep result stream.
module tb_tof_echo_timer;

    localparam int MAXD  = 256;
    localparam int SLOTS = 8;

    logic       clk = 1'b0;
    logic       rst, clk_en, start_pulse, echo_pulse, meas_ready;
    logic       meas_valid, meas_timeout, start_drop, stray_echo, meas_drop;
    logic [7:0] meas_delay;
    logic [3:0] pending_o;

    always #5 clk = ~clk;

    tof_echo_timer #(.MAX_DELAY(MAXD), .SLOTS(SLOTS)) dut (
        .clk          (clk),
        .rst          (rst),
        .clk_en       (clk_en),
        .start_pulse  (start_pulse),
        .echo_pulse   (echo_pulse),
        .meas_valid   (meas_valid),
        .meas_ready   (meas_ready),
        .meas_delay   (meas_delay),
        .meas_timeout (meas_timeout),
        .pending_o    (pending_o),
        .start_drop   (start_drop),
        .stray_echo   (stray_echo),
        .meas_drop    (meas_drop)
    );

    typedef struct {
        bit tmo;
        int d;
    } res_t;

    int   passed = 0;
    int   failed = 0;
    int   total  = 0;
    int   pq[$];
    res_t rq[$];
    int   now = 0;
    bit   x_sd, x_se, x_md;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Model: pending starts are enabled-cycle timestamps; delay = echo time - start time - 1.
    task automatic model(input bit st, input bit ec, input bit rdy, input bit en, input bit rs);
        bit   have, full, pop;
        res_t r;
        x_sd = 1'b0;
        x_se = 1'b0;
        x_md = 1'b0;
        if (rs) begin
            pq.delete();
            rq.delete();
            return;
        end
        if (!en) return;
        have  = 1'b0;
        r.tmo = 1'b0;
        r.d   = 0;
        if (ec && pq.size() > 0) begin
            r.d  = now - pq[0] - 1;
            have = 1'b1;
            void'(pq.pop_front());
        end else if (ec) begin
            x_se = 1'b1;
        end else if (pq.size() > 0 && (now - pq[0]) == MAXD) begin
            r.tmo = 1'b1;
            r.d   = MAXD - 1;
            have  = 1'b1;
            void'(pq.pop_front());
        end
        if (st) begin
            if (pq.size() < SLOTS) pq.push_back(now);
            else x_sd = 1'b1;
        end
        full = (rq.size() == 2);
        pop  = rdy && (rq.size() > 0);
        if (pop) void'(rq.pop_front());
        if (have) begin
            if (!full || pop) rq.push_back(r);
            else x_md = 1'b1;
        end
        now++;
    endtask

    task automatic check_all();
        bit v;
        v = (rq.size() > 0);
        chk("meas_valid",   32'(meas_valid),   32'(v));
        chk("meas_delay",   32'(meas_delay),   v ? rq[0].d : 0);
        chk("meas_timeout", 32'(meas_timeout), v ? 32'(rq[0].tmo) : 0);
        chk("pending_o",    32'(pending_o),    pq.size());
        chk("start_drop",   32'(start_drop),   32'(x_sd));
        chk("stray_echo",   32'(stray_echo),   32'(x_se));
        chk("meas_drop",    32'(meas_drop),    32'(x_md));
    endtask

    task automatic step(input bit st, input bit ec, input bit rdy, input bit en);
        start_pulse = st;
        echo_pulse  = ec;
        meas_ready  = rdy;
        clk_en      = en;
        model(st, ec, rdy, en, rst);
        @(posedge clk);
        #1;
        check_all();
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) step(1'b0, 1'b0, 1'b1, 1'b1);
    endtask

    int dl[4] = '{0, 1, 37, 255};

    initial begin
        rst = 1'b1; clk_en = 1'b1; start_pulse = 1'b0; echo_pulse = 1'b0; meas_ready = 1'b1;
        step(0, 0, 1, 1);
        step(0, 0, 1, 1);
        chk("reset_pending", 32'(pending_o), 0);
        chk("reset_valid", 32'(meas_valid), 0);
        rst = 1'b0;

        // Basic: start@t0, echo@t0+6 -> delay 5
        step(1, 0, 1, 1);
        chk("basic_pending1", 32'(pending_o), 1);
        idle(5);
        step(0, 1, 1, 1);
        chk("basic_valid", 32'(meas_valid), 1);
        chk("basic_delay", 32'(meas_delay), 5);
        chk("basic_tmo", 32'(meas_timeout), 0);
        chk("basic_pending0", 32'(pending_o), 0);
        idle(1);

        // Loopback delays
        for (int j = 0; j < 4; j++) begin
            step(1, 0, 1, 1);
            idle(dl[j]);
            step(0, 1, 1, 1);
            chk("loop_delay", 32'(meas_delay), dl[j]);
            chk("loop_nodrop", 32'(meas_drop | start_drop), 0);
            idle(1);
        end

        // Timeout, then echo exactly at the timeout cycle
        step(1, 0, 1, 1);
        idle(256);
        chk("tmo_valid", 32'(meas_valid), 1);
        chk("tmo_delay", 32'(meas_delay), 255);
        chk("tmo_flag", 32'(meas_timeout), 1);
        idle(1);
        step(1, 0, 1, 1);
        idle(255);
        step(0, 1, 1, 1);
        chk("late_delay", 32'(meas_delay), 255);
        chk("late_flag", 32'(meas_timeout), 0);
        idle(1);

        // Full pending FIFO
        for (int k = 0; k < 8; k++) step(1, 0, 1, 1);
        step(1, 0, 1, 1);
        chk("full_drop", 32'(start_drop), 1);
        chk("full_pending", 32'(pending_o), 8);
        step(1, 1, 1, 1);
        chk("full_swap_nodrop", 32'(start_drop), 0);
        chk("full_swap_pending", 32'(pending_o), 8);
        chk("full_swap_delay", 32'(meas_delay), 8);
        for (int k = 0; k < 8; k++) step(0, 1, 1, 1);
        idle(1);

        // Stray echoes
        step(0, 1, 1, 1);
        chk("stray", 32'(stray_echo), 1);
        step(1, 1, 1, 1);
        chk("stray_start", 32'(stray_echo), 1);
        chk("stray_start_pend", 32'(pending_o), 1);
        step(0, 1, 1, 1);
        idle(1);

        // Result FIFO backpressure
        for (int k = 0; k < 3; k++) step(1, 0, 0, 1);
        for (int k = 0; k < 3; k++) step(0, 1, 0, 1);
        chk("bp_drop", 32'(meas_drop), 1);
        chk("bp_valid", 32'(meas_valid), 1);
        idle(2);

        // Clock-enable gating freezes ages
        step(1, 0, 1, 1);
        idle(3);
        for (int k = 0; k < 10; k++)
            step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b0);
        idle(2);
        step(0, 1, 1, 1);
        chk("gate_delay", 32'(meas_delay), 5);
        idle(1);

        // Reset mid-stream
        step(1, 0, 0, 1);
        step(1, 0, 0, 1);
        step(0, 1, 0, 1);
        rst = 1'b1;
        step(1, 1, 1, 1);
        chk("rst_valid", 32'(meas_valid), 0);
        chk("rst_pending", 32'(pending_o), 0);
        rst = 1'b0;

        // Random dense traffic
        for (int k = 0; k < 3000; k++) begin
            rst = ($urandom_range(0, 299) == 0);
            step($urandom_range(0, 99) < 35, $urandom_range(0, 99) < 30,
                 $urandom_range(0, 99) < 70, $urandom_range(0, 99) < 90);
        end
        rst = 1'b0;
        // Random sparse traffic to exercise timeouts
        for (int k = 0; k < 1500; k++) begin
            step($urandom_range(0, 99) < 3, $urandom_range(0, 199) < 1,
                 $urandom_range(0, 99) < 60, $urandom_range(0, 99) < 95);
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
